// File: rtl/conv_encoder_tb_param_if.sv
// Bundle of FIFO-side and status signals around the tail-biting
// convolutional encoder.
//   master : the environment (drives FIFO flags/data, out_full, blk_ready)
//   slave  : the encoder (drives read requests, encoded words, status)
// Signals:
//   blk_ready        start request
//   meta_empty/meta_q, meta_rdreq   meta FIFO side (q valid 1 cycle after rdreq)
//   data_empty/data_q, data_rdreq   data FIFO side (q valid 1 cycle after rdreq)
//   out_full         any output FIFO full
//   out0..out2, out_valid           encoded words and common write strobe
//   busy, computation_done, word_count   status
interface conv_encoder_tb_param_if #(
  parameter int DATA_W = 8
);
  logic              blk_ready;
  logic              meta_empty;
  logic [DATA_W-1:0] meta_q;
  logic              data_empty;
  logic [DATA_W-1:0] data_q;
  logic              out_full;
  logic              meta_rdreq;
  logic              data_rdreq;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              out_valid;
  logic              busy;
  logic              computation_done;
  logic [12:0]       word_count;

  modport master (
    output blk_ready, meta_empty, meta_q, data_empty, data_q, out_full,
    input  meta_rdreq, data_rdreq, out0, out1, out2, out_valid, busy,
           computation_done, word_count
  );

  modport slave (
    input  blk_ready, meta_empty, meta_q, data_empty, data_q, out_full,
    output meta_rdreq, data_rdreq, out0, out1, out2, out_valid, busy,
           computation_done, word_count
  );
endinterface

// File: rtl/conv_encoder_tb_param.sv
// Parametrised tail-biting rate-1/3 convolutional encoder.
// A block (K_SMALL or K_LARGE bits, chosen by meta_q[0]) is read word by
// word from the data FIFO into an internal buffer. The encoder state is
// then primed with the last CL-1 bits of the block, and the buffer is
// encoded DATA_W bits per cycle into three output streams.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    conv_encoder_tb_param_if.slave (FIFO handshakes, outputs, status)
module conv_encoder_tb_param #(
  parameter int            DATA_W  = 8,
  parameter int            CL      = 7,
  parameter logic [CL-1:0] G0      = 7'o133,
  parameter logic [CL-1:0] G1      = 7'o171,
  parameter logic [CL-1:0] G2      = 7'o165,
  parameter int            K_SMALL = 1056,
  parameter int            K_LARGE = 6144
) (
  input  logic                    clk,
  input  logic                    reset,
  conv_encoder_tb_param_if.slave  bus
);

  localparam int          NW_S   = K_SMALL / DATA_W;
  localparam int          NW_L   = K_LARGE / DATA_W;
  localparam int          AW     = $clog2(NW_L);
  localparam int          HW     = DATA_W + CL - 1;
  localparam logic [12:0] NW_S13 = 13'(NW_S);
  localparam logic [12:0] NW_L13 = 13'(NW_L);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_META   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_PRIME  = 3'd3;
  localparam logic [2:0] S_ENCODE = 3'd4;

  generate
    if ((K_SMALL % DATA_W) != 0 || (K_LARGE % DATA_W) != 0) begin : g_bad_k
      $error("K_SMALL and K_LARGE must be multiples of DATA_W");
    end
  endgenerate

  // h holds bits oldest-first from MSB: h[DATA_W-1-t] = c[k0+t] for
  // t = -(CL-1)..DATA_W-1, so output bit b needs taps h[b..b+CL-1].
  function automatic logic [DATA_W-1:0] enc_word(input logic [CL-1:0] g,
                                                 input logic [HW-1:0] h);
    logic [DATA_W-1:0] d;
    for (int b = 0; b < DATA_W; b++) begin
      d[b] = 1'b0;
      for (int j = 0; j < CL; j++) begin
        d[b] = d[b] ^ (g[CL-1-j] & h[b+j]);
      end
    end
    return d;
  endfunction

  logic [2:0]        state;
  logic              size_flag;
  logic [12:0]       nw;
  logic [12:0]       word_count;
  logic [12:0]       req_cnt;
  logic [12:0]       rd_addr;
  logic              rd_pend;
  logic [CL-2:0]     sr;
  logic [CL-2:0]     tail;
  logic [HW-1:0]     tail_cat;
  logic [DATA_W-1:0] buffer [NW_L];
  logic [DATA_W-1:0] rd_word_p0;
  logic              vld_p0;
  logic [HW-1:0]     h_p0;
  logic [DATA_W-1:0] out0_p1, out1_p1, out2_p1;
  logic              vld_p1;
  logic              p1_adv, load_p0, fetch_p0, out_valid, done;
  logic              unused_bits;

  assign nw        = size_flag ? NW_L13 : NW_S13;
  assign tail_cat  = {tail, bus.data_q};
  assign h_p0      = {sr, rd_word_p0};
  // The write strobe is masked by out_full so a held word is never lost.
  assign out_valid = vld_p1 & ~bus.out_full;
  assign done      = out_valid & (word_count == nw - 13'd1);
  assign p1_adv    = (state == S_ENCODE) & (~vld_p1 | ~bus.out_full);
  assign load_p0   = p1_adv & vld_p0 & (rd_addr < nw);
  assign fetch_p0  = (state == S_PRIME) | load_p0;

  assign bus.meta_rdreq       = (state == S_IDLE) & bus.blk_ready & ~bus.meta_empty;
  assign bus.data_rdreq       = (state == S_LOAD) & ~bus.data_empty & (req_cnt < nw);
  assign bus.out0             = out0_p1;
  assign bus.out1             = out1_p1;
  assign bus.out2             = out2_p1;
  assign bus.out_valid        = out_valid;
  assign bus.busy             = (state != S_IDLE);
  assign bus.computation_done = done;
  assign bus.word_count       = word_count;
  assign unused_bits          = ^{bus.meta_q[DATA_W-1:1], tail_cat[HW-1:CL-1]};

  // p0: block buffer write (LOAD) and registered buffer read (PRIME/ENCODE)
  always_ff @(posedge clk) begin
    if (state == S_LOAD && rd_pend) begin
      buffer[word_count[AW-1:0]] <= bus.data_q;
      tail                       <= tail_cat[CL-2:0];
    end
    if (fetch_p0) begin
      rd_word_p0 <= buffer[rd_addr[AW-1:0]];
    end
  end

  // p1: control, encoder state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      size_flag  <= 1'b0;
      word_count <= '0;
      req_cnt    <= '0;
      rd_addr    <= '0;
      rd_pend    <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      sr         <= '0;
      out0_p1    <= '0;
      out1_p1    <= '0;
      out2_p1    <= '0;
    end else begin
      rd_pend <= bus.data_rdreq;
      case (state)
        S_IDLE: begin
          if (bus.meta_rdreq) state <= S_META;
        end
        S_META: begin
          size_flag  <= bus.meta_q[0];
          word_count <= '0;
          req_cnt    <= '0;
          rd_addr    <= '0;
          state      <= S_LOAD;
        end
        S_LOAD: begin
          if (bus.data_rdreq) req_cnt <= req_cnt + 13'd1;
          if (rd_pend) begin
            word_count <= word_count + 13'd1;
            if (word_count == nw - 13'd1) state <= S_PRIME;
          end
        end
        S_PRIME: begin
          // tail[j] is c[K-1-j]: the wrap-around start state.
          sr         <= tail;
          word_count <= '0;
          rd_addr    <= 13'd1;
          vld_p0     <= 1'b1;
          state      <= S_ENCODE;
        end
        S_ENCODE: begin
          if (p1_adv) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
              out0_p1 <= enc_word(G0, h_p0);
              out1_p1 <= enc_word(G1, h_p0);
              out2_p1 <= enc_word(G2, h_p0);
              sr      <= h_p0[CL-2:0];
              if (load_p0) rd_addr <= rd_addr + 13'd1;
              else         vld_p0  <= 1'b0;
            end
          end
          if (out_valid) begin
            if (done) begin
              word_count <= '0;
              state      <= S_IDLE;
            end else begin
              word_count <= word_count + 13'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_tb_param.sv
// Bench for conv_encoder_tb_param: FIFO models on both sides, a bit-serial
// circular-convolution golden model feeding a scoreboard queue, and a
// negedge monitor comparing every written word.
module tb_conv_encoder_tb_param;

  localparam int          DATA_W  = 8;
  localparam int          CL      = 7;
  localparam logic [6:0]  G0      = 7'o133;
  localparam logic [6:0]  G1      = 7'o171;
  localparam logic [6:0]  G2      = 7'o165;
  localparam int          K_SMALL = 1056;
  localparam int          K_LARGE = 6144;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_encoder_tb_param_if #(.DATA_W(DATA_W)) bus ();

  conv_encoder_tb_param #(
    .DATA_W(DATA_W), .CL(CL), .G0(G0), .G1(G1), .G2(G2),
    .K_SMALL(K_SMALL), .K_LARGE(K_LARGE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO models
  logic [7:0] dmem [0:4095];
  logic [7:0] mmem [0:15];
  int d_wr = 0, d_rd = 0, m_wr = 0, m_rd = 0;
  logic force_empty = 1'b0;
  logic full_en = 1'b0;
  int   full_ph = 0;

  assign bus.data_empty = (d_wr == d_rd) || force_empty;
  assign bus.meta_empty = (m_wr == m_rd);

  always @(posedge clk) begin
    if (bus.data_rdreq) begin
      bus.data_q <= dmem[d_rd];
      d_rd       <= d_rd + 1;
    end
    if (bus.meta_rdreq) begin
      bus.meta_q <= mmem[m_rd];
      m_rd       <= m_rd + 1;
    end
    full_ph      <= (full_ph == 4) ? 0 : full_ph + 1;
    bus.out_full <= full_en && (full_ph < 3);
  end

  // Scoreboard: {out0, out1, out2, computation_done}
  logic [24:0] exp_q [$];
  logic [23:0] obs [0:8191];
  int obs_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    logic [24:0] e;
    if (bus.out_full === 1'b1) chk("vld_while_full", {31'd0, bus.out_valid}, 32'd0);
    if (bus.computation_done && !bus.out_valid)
      chk("done_wo_valid", {31'd0, bus.computation_done}, 32'd0);
    if (bus.computation_done) done_cnt <= done_cnt + 1;
    if (bus.out_valid) begin
      obs[obs_cnt] <= {bus.out0, bus.out1, bus.out2};
      obs_cnt      <= obs_cnt + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("word", {7'd0, bus.out0, bus.out1, bus.out2, bus.computation_done}, {7'd0, e});
      end
    end
  end

  logic [7:0] blk   [0:767];
  logic [7:0] saved [0:767];

  // Golden model: circular convolution over the block bits, MSB first.
  task automatic model(input int nbytes);
    bit c [6144];
    int kbits, idx;
    logic [7:0] o0, o1, o2;
    logic d0, d1, d2;
    kbits = nbytes * 8;
    for (int k = 0; k < kbits; k++) c[k] = blk[k/8][7-(k%8)];
    for (int w = 0; w < nbytes; w++) begin
      for (int i = 0; i < 8; i++) begin
        d0 = 1'b0; d1 = 1'b0; d2 = 1'b0;
        for (int j = 0; j < CL; j++) begin
          idx = (8*w + i - j + kbits) % kbits;
          d0 = d0 ^ (G0[CL-1-j] & c[idx]);
          d1 = d1 ^ (G1[CL-1-j] & c[idx]);
          d2 = d2 ^ (G2[CL-1-j] & c[idx]);
        end
        o0[7-i] = d0; o1[7-i] = d1; o2[7-i] = d2;
      end
      exp_q.push_back({o0, o1, o2, (w == nbytes - 1)});
    end
  endtask

  task automatic load_block(input logic [7:0] meta, input bit push_meta, input int nbytes);
    if (push_meta) begin
      mmem[m_wr] = meta;
      m_wr++;
    end
    for (int i = 0; i < nbytes; i++) begin
      dmem[d_wr] = blk[i];
      d_wr++;
    end
    model(nbytes);
  endtask

  task automatic start_blk();
    @(posedge clk); #1 bus.blk_ready = 1'b1;
    @(posedge clk); #1 bus.blk_ready = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || exp_q.size() != 0) && n < budget);
    if (bus.busy || exp_q.size() != 0)
      chk("timeout_busy", {30'd0, bus.busy, exp_q.size() != 0}, 32'd0);
  endtask

  task automatic run_and_check(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    start_blk();
    wait_idle(budget);
    chk({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    chk({tag, "_exp_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    bus.blk_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("rst_done",   {31'd0, bus.computation_done}, 32'd0);
    chk("rst_wcnt",   {19'd0, bus.word_count}, 32'd0);
    chk("rst_outs",   {8'd0, bus.out0, bus.out1, bus.out2}, 32'd0);
    chk("rst_rdreqs", {30'd0, bus.meta_rdreq, bus.data_rdreq}, 32'd0);
    reset = 1'b1;

    // All-zero small block
    for (int i = 0; i < 132; i++) blk[i] = 8'h00;
    load_block(8'h00, 1'b1, 132);
    run_and_check("zeros", 2000);

    // Tail-biting impulse
    for (int i = 0; i < 132; i++) blk[i] = 8'h00;
    blk[131] = 8'h01;
    base = obs_cnt;
    load_block(8'h00, 1'b1, 132);
    run_and_check("impulse", 2000);
    chk("imp_first", {8'd0, obs[base]}, 32'h006CE4D4);
    chk("imp_last",  {8'd0, obs[base+131]}, 32'h00010101);

    // Large random block
    for (int i = 0; i < 768; i++) begin
      blk[i]   = 8'($urandom);
      saved[i] = blk[i];
    end
    load_block(8'h01, 1'b1, 768);
    run_and_check("large", 5000);

    // Same block, meta upper bits set, out_full 3 high / 2 low
    for (int i = 0; i < 768; i++) blk[i] = saved[i];
    load_block(8'hFD, 1'b1, 768);
    full_en = 1'b1;
    run_and_check("backpressure", 8000);
    full_en = 1'b0;

    // data_empty stall mid-LOAD, blk_ready pulsed during ENCODE
    for (int i = 0; i < 132; i++) blk[i] = 8'($urandom);
    load_block(8'hFE, 1'b1, 132);
    n = done_cnt;
    start_blk();
    for (int i = 0; i < 2000 && bus.word_count < 13'd40; i++) @(negedge clk);
    @(posedge clk); #1 force_empty = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rdreq_while_empty", {31'd0, bus.data_rdreq}, 32'd0);
    end
    @(posedge clk); #1 force_empty = 1'b0;
    for (int i = 0; i < 2000 && !bus.out_valid; i++) @(negedge clk);
    mmem[m_wr] = 8'h00;   // pending meta; consumed by the reset test below
    m_wr++;
    start_blk();
    wait_idle(2000);
    chk("stall_done_pulses", done_cnt - n, 32'd1);
    repeat (20) @(negedge clk);
    chk("extra_blk_busy",  {31'd0, bus.busy}, 32'd0);
    chk("extra_blk_meta",  m_rd, m_wr - 1);

    // Reset mid-ENCODE
    for (int i = 0; i < 132; i++) blk[i] = 8'h00;
    load_block(8'h00, 1'b0, 132);
    base = obs_cnt;
    start_blk();
    for (int i = 0; i < 2000 && obs_cnt < base + 20; i++) @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_wcnt",  {19'd0, bus.word_count}, 32'd0);
    chk("mid_rst_outs",  {8'd0, bus.out0, bus.out1, bus.out2}, 32'd0);
    chk("mid_rst_done",  {31'd0, bus.computation_done}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_encoder_tb_param.md
Name: conv_encoder_tb_param

Overview:
- Parametrised tail-biting convolutional encoder; successor to the fixed rate-1/3, byte-wide encoder that sits between the input data/meta FIFOs and the three output FIFOs.
- Generalised in data width, constraint length, generator polynomials and the two block sizes.
- Adds an internal block buffer for true tail-biting initialisation, downstream backpressure (out_full) and empty-FIFO stalling.

Parameters:
- DATA_W, 8, bits per FIFO word and per output word.
- CL, 7, constraint length; the shift register holds CL-1 bits.
- G0, 7'o133, generator 0. MSB is the tap on the current bit.
- G1, 7'o171, generator 1.
- G2, 7'o165, generator 2.
- K_SMALL, 1056, block length in bits when meta[0]=0.
- K_LARGE, 6144, block length in bits when meta[0]=1.
- Constraint: K_SMALL and K_LARGE must be multiples of DATA_W, otherwise elaboration fails.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- blk_ready  in  1  start request; sampled only in IDLE.
- meta_empty  in  1  meta FIFO empty.
- meta_q  in  DATA_W  meta FIFO output; valid the cycle after meta_rdreq.
- data_empty  in  1  data FIFO empty.
- data_q  in  DATA_W  data FIFO output; valid the cycle after data_rdreq.
- out_full  in  1  any output FIFO full.
- meta_rdreq  out  1  meta FIFO read request.
- data_rdreq  out  1  data FIFO read request.
- out0, out1, out2  out  DATA_W each  encoded words for streams d0, d1, d2.
- out_valid  out  1  write strobe to all three output FIFOs.
- busy  out  1  high in any state other than IDLE.
- computation_done  out  1  one-cycle pulse when a block completes.
- word_count  out  13  words read (LOAD) or emitted (ENCODE) so far in the block.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs, counters, shift register and size flag cleared to 0. Buffer contents are don't-care. Reset mid-block abandons the block; there is no partial output after release.
- IDLE: when blk_ready=1 and meta_empty=0, assert meta_rdreq for 1 cycle and go to META. blk_ready is ignored when not in IDLE.
- META: latch meta_q[0] as the size flag. NW = K/DATA_W. Clear word_count and go to LOAD.
- LOAD: assert data_rdreq whenever data_empty=0 and the number of requests issued is below NW. Write each returned word (1 cycle later) into buffer[word_count] and increment word_count. When word_count reaches NW, go to PRIME. data_empty stalls LOAD without losing words.
- PRIME (1 cycle): shift register s[j] = c[K-1-j] for j=0..CL-2, i.e. the last CL-1 bits of the block, taken from the buffer. Clear word_count and go to ENCODE.
- Bit order: within a word, the MSB is first in time.
- ENCODE: each cycle with out_full=0, process buffer word word_count (DATA_W bits in parallel):
  - d_i[k] = XOR over j=0..CL-1 of G_i[CL-1-j] & c[k-j].
  - c[k-j] for k-j<0 comes from the shift register.
  - Results are registered into out0..out2 with out_valid=1.
  - The shift register advances by DATA_W bits.
  - word_count increments.
- ENCODE backpressure: out_full=1 holds all state, forces out_valid=0 and holds out0..out2. No word is skipped or duplicated.
- ENCODE end: after word NW-1 is emitted, pulse computation_done in the same cycle as the last out_valid, then return to IDLE.
- Latency: first out_valid comes 2 cycles after PRIME. Steady throughput is 1 word per cycle.
- Arithmetic: word_count wraps only by returning to IDLE. It never exceeds NW.
- Buffer: depth K_LARGE/DATA_W words, single write port plus read port(s); implementation choice.

Test Plan:
1. Reset asserted mid-ENCODE -> all outputs 0 immediately. After release, state=IDLE and no out_valid until a new blk_ready.
2. meta=0x00, 132 data bytes of 0x00 -> 132 out_valid pulses, all outputs 0x00, computation_done on the 132nd.
3. Tail-biting impulse: meta=0x00, bytes 0..130 = 0x00, byte 131 = 0x01 -> first word out0=0x6C, out1=0xE4, out2=0xD4. Last word is 0x01 on all three streams. Every other word is 0x00.
4. meta=0x01, 768 random bytes -> 768 words that match the golden model bit-exactly; computation_done is a single pulse.
5. out_full toggling 3 cycles high / 2 cycles low during ENCODE -> identical output sequence to test 4, with no out_valid while out_full=1.
6. data_empty held high for 10 cycles mid-LOAD, and blk_ready pulsed during ENCODE -> LOAD resumes with no lost bytes; the extra blk_ready is ignored and the output matches the golden model.
